// File: rtl/bit_deserializer_pkg.sv
// Shared constants and output-state encoding for the serial-to-parallel packer.
package bit_deserializer_pkg;

  localparam int unsigned WidthDefault    = 8;
  localparam int unsigned CntWidthDefault = $clog2(WidthDefault);

  // Bit-counter width for a given word width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/bit_deserializer.sv
// Packs a qualified serial bit stream LSB-first into WIDTH-bit words held in a
// one-entry output register with a sticky overflow flag for dropped words.
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int unsigned     CntW   = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] out_q, out_d;
  state_e           state_q, state_d;
  logic             overflow_q, overflow_d;
  logic             word_done;

  always_comb begin
    word_done  = in_valid && (cnt_q == CntMax);
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    out_d      = out_q;
    state_d    = state_q;
    overflow_d = overflow_q;

    // Shift right so the oldest bit ends up at sr[0]; stale contents after a
    // completed word are fully overwritten by the next WIDTH-1 bits.
    if (in_valid) begin
      cnt_d           = word_done ? '0 : cnt_q + 1'b1;
      sr_d            = sr_q >> 1;
      sr_d[WIDTH-2]   = in;
    end

    unique case (state_q)
      StEmpty: begin
        if (word_done) begin
          state_d = StFull;
          out_d   = {in, sr_q};
        end
      end
      StFull: begin
        if (word_done) begin
          if (out_ready) begin
            out_d = {in, sr_q};
          end else begin
            overflow_d = 1'b1;
          end
        end else if (out_ready) begin
          state_d = StEmpty;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      out_q      <= '0;
      state_q    <= StEmpty;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      out_q      <= out_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Single-bit state encoding: out_valid is the state flop itself.
  assign out       = out_q;
  assign out_valid = (state_q == StFull);
  assign overflow  = overflow_q;

endmodule
